fpr_muldiv: RTL and testbench
=============================

Name: fpr_muldiv

Overview:
Iterative 32-bit integer multiply/divide unit for the FP-register-file operand path (mult, multu, div, divu).
- Consumes the two operands read from the FP register file.
- Produces a 32-bit result that the control FSM steers onto the register file write bus.
- Runs alongside the multi-cycle datapath; the controller stalls on busy and writes back on done.

Parameters:
- WIDTH, 32, operand and result width.
- ITERS, 32, shift/add or shift/subtract iterations; must equal WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request; accepted only in IDLE.
- op  in  2  00 multu, 01 mult, 10 divu, 11 div; sampled with start.
- opA  in  WIDTH  multiplicand / dividend (register file busA).
- opB  in  WIDTH  multiplier / divisor (register file busB).
- busy  out  1  high from acceptance until return to IDLE.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  low 32 bits of product, or quotient.
- div_by_zero  out  1  valid with done; high if a divide had opB==0.

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, result=0, div_by_zero=0; counter, accumulators and sign flag cleared.
- States: IDLE, RUN, FIX, DONE.
- IDLE: start=1 at edge N:
  - latch op.
  - latch |opA| and |opB| (signed ops take two's-complement magnitude; unsigned ops pass through).
  - latch neg_flag = signA XOR signB, signed ops only.
  - count=0; go to RUN.
  - busy=1 after edge N.
- RUN: one iteration per edge, edges N+1..N+32.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit remainder plus 32-bit quotient.
  - count increments each edge; at count==ITERS-1 the next state is FIX.
- FIX (edge N+33):
  - result = low 32 bits of product, or quotient.
  - negate if neg_flag.
  - go to DONE.
- DONE: done=1 for exactly the cycle after edge N+33; edge N+34 returns to IDLE and busy=0.
- Latency: done asserts 33 cycles after the accepting edge; fixed and independent of data.
- Write-back timing: result is stable throughout the done cycle. The register file writes on the falling edge, so write-enable may be derived combinationally from done.
- Hold: result and div_by_zero hold their values after DONE until the next accepted start.
- start while busy: ignored; no queuing; op/opA/opB are not re-sampled.
- Operand hold: operands are captured at acceptance; changes to opA/opB during RUN have no effect.
- Divide by zero:
  - full latency still runs.
  - result=0xFFFFFFFF for both div and divu; sign fix is suppressed.
  - div_by_zero=1.
- Signed division rounds toward zero. Remainder is discarded.
- 0x80000000 / 0xFFFFFFFF (div) yields 0x80000000 by wrap; no exception.
- Multiply overflow: upper 32 bits are discarded; no flag.
- Reset during RUN/FIX/DONE: operation aborts immediately; no done pulse; next start behaves normally.
- start asserted in the same cycle reset deasserts: accepted at the next rising edge if reset is low there.

Decomposition:
- Shared package (muldiv_pkg):
  - op encodings OP_MULTU, OP_MULT, OP_DIVU, OP_DIV.
  - state enum {IDLE, RUN, FIX, DONE}.
  - ITERS constant.
  - DIV0_RESULT = 32'hFFFFFFFF.
- One combinational sub-module, twos_mag: WIDTH-bit value plus a signed flag -> magnitude. Used at load for both operands; its negate path is reused in FIX.

Test Plan:
- multu opA=7, opB=6 -> done exactly 33 cycles after the accepting edge; result=0x0000002A; div_by_zero=0; busy falls one cycle after done.
- mult 0xFFFFFFFD × 5 -> 0xFFFFFFF1. mult 0x00010000 × 0x00010000 -> 0x00000000 (overflow truncated).
- divu 100/7 -> 0x0000000E. div 0xFFFFFFF9/2 -> 0xFFFFFFFD. div 0x80000000/0xFFFFFFFF -> 0x80000000.
- divu 5/0 and div 0xFFFFFFFB/0 -> result=0xFFFFFFFF, div_by_zero=1, full 33-cycle latency.
- Ignored start: start multu 3×4, pulse start with divu 9/3 at cycle 10, change opA mid-RUN -> single done, result=0x0000000C, no second done.
- Reset mid-operation: assert reset at cycle 15 of a divide -> busy/done/result=0 without waiting for a clock edge. Release reset, then multu 2×3 -> result=6 after 33 cycles.

Source files
------------

// File: rtl/fpr_muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Latency/backpressure: not applicable (declarations only).
package fpr_muldiv_pkg;

  localparam int ITERS = 32;
  localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/fpr_muldiv_if.sv
// Request/result bundle between the register-file controller and the muldiv unit.
// Latency/backpressure: wires only; the requester must respect busy.
interface fpr_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, op, opA, opB,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, opA, opB,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/fpr_muldiv_twos_mag.sv
// Conditional two's-complement negate: magnitude of a signed value, or forced negate.
// Latency: combinational; no backpressure.
module fpr_muldiv_twos_mag #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             sgn_i,
  input  logic             inv_i,
  output logic [WIDTH-1:0] mag_o
);
  logic flip;

  assign flip  = inv_i | (sgn_i & val_i[WIDTH-1]);
  assign mag_o = flip ? ((~val_i) + WIDTH'(1)) : val_i;
endmodule

// File: rtl/fpr_muldiv.sv
// Iterative 32-bit mult/multu/div/divu; done pulses 33 cycles after the accepting edge.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped.
module fpr_muldiv #(
  parameter int WIDTH = 32,
  parameter int ITERS = fpr_muldiv_pkg::ITERS
) (
  input  logic         clk,
  input  logic         reset,
  fpr_muldiv_if.slave  bus
);
  import fpr_muldiv_pkg::*;

  localparam int CW = $clog2(ITERS);

  state_e             state_q;
  logic               is_div_q;
  logic               neg_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic               dbz_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   fix_val;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_step_d;
  logic [2*WIDTH-1:0] div_step_d;

  fpr_muldiv_twos_mag #(.WIDTH(WIDTH)) u_mag_a (
    .val_i (bus.opA),
    .sgn_i (op_is_signed(bus.op)),
    .inv_i (1'b0),
    .mag_o (mag_a)
  );

  fpr_muldiv_twos_mag #(.WIDTH(WIDTH)) u_mag_b (
    .val_i (bus.opB),
    .sgn_i (op_is_signed(bus.op)),
    .inv_i (1'b0),
    .mag_o (mag_b)
  );

  // Sign fix of the unsigned result reuses the same negate datapath.
  fpr_muldiv_twos_mag #(.WIDTH(WIDTH)) u_fix (
    .val_i (acc_q[WIDTH-1:0]),
    .sgn_i (1'b0),
    .inv_i (neg_q),
    .mag_o (fix_val)
  );

  // Multiply: hi += multiplicand when multiplier LSB set, then shift the pair right.
  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_step_d = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: restoring step; remainder in the high half, quotient shifts into the low half.
  assign div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff   = div_rem_sh - {1'b0, b_q};
  assign div_step_d = div_diff[WIDTH]
                    ? {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                    : {div_diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            is_div_q <= op_is_div(bus.op);
            neg_q    <= op_is_signed(bus.op) & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
            a_q      <= mag_a;
            b_q      <= mag_b;
            acc_q    <= {{WIDTH{1'b0}}, (op_is_div(bus.op) ? mag_a : mag_b)};
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q <= is_div_q ? div_step_d : mul_step_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(ITERS - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (is_div_q && (b_q == '0)) begin
            result_q <= WIDTH'(DIV0_RESULT);
            dbz_q    <= 1'b1;
          end else begin
            result_q <= fix_val;
            dbz_q    <= 1'b0;
          end
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_fpr_muldiv.sv
// Directed-vector bench for fpr_muldiv: latency, results, div-by-zero, ignored start, async reset.
module tb_fpr_muldiv;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   dones;
  int   lat;
  logic [31:0] res_seen;

  fpr_muldiv_if #(.WIDTH(32)) bus ();

  fpr_muldiv #(.WIDTH(32), .ITERS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z);
    int l;
    l = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.opA   = a;
    bus.opB   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.opA   = $urandom;
    bus.opB   = $urandom;
    chk({tag, ":busy_after_accept"}, {31'b0, bus.busy}, 32'd1);
    for (int c = 1; c <= 40 && l == 0; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) l = c;
    end
    chk({tag, ":latency"}, l, 32'd33);
    chk({tag, ":result"}, bus.result, exp_r);
    chk({tag, ":div_by_zero"}, {31'b0, bus.div_by_zero}, {31'b0, exp_z});
    @(posedge clk);
    #1;
    chk({tag, ":busy_clear"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, ":done_pulse"}, {31'b0, bus.done}, 32'd0);
    chk({tag, ":result_hold"}, bus.result, exp_r);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.opA   = '0;
    bus.opB   = '0;
    #1;
    chk("rst:busy", {31'b0, bus.busy}, 32'd0);
    chk("rst:done", {31'b0, bus.done}, 32'd0);
    chk("rst:result", bus.result, 32'd0);
    chk("rst:dbz", {31'b0, bus.div_by_zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op("multu_7x6",     2'b00, 32'd7,          32'd6,          32'h0000_002A, 1'b0);
    run_op("mult_neg3x5",   2'b01, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 1'b0);
    run_op("mult_ovf",      2'b01, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000, 1'b0);
    run_op("multu_max",     2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 1'b0);
    run_op("divu_100_7",    2'b10, 32'd100,        32'd7,          32'h0000_000E, 1'b0);
    run_op("div_neg7_2",    2'b11, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 1'b0);
    run_op("div_100_neg7",  2'b11, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2, 1'b0);
    run_op("div_wrap",      2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b0);
    run_op("divu_by0",      2'b10, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1);
    run_op("div_neg_by0",   2'b11, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF, 1'b1);
    run_op("mult_after_z",  2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 1'b0);

    // Second start during RUN and operand changes must not disturb the 3x4 product.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.opA   = 32'd3;
    bus.opB   = 32'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones    = 0;
    lat      = 0;
    res_seen = '0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 10) begin
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.opA   = 32'd9;
        bus.opB   = 32'd3;
      end
      if (c == 11) bus.start = 1'b0;
      if (c == 20) bus.opA = 32'h0000_00FF;
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        if (lat == 0) begin
          lat      = c;
          res_seen = bus.result;
        end
      end
    end
    chk("ign:done_count", dones, 32'd1);
    chk("ign:latency", lat, 32'd33);
    chk("ign:result", res_seen, 32'h0000_000C);
    chk("ign:idle_busy", {31'b0, bus.busy}, 32'd0);

    // Async reset part-way through a divide.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.opA   = 32'd100;
    bus.opB   = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("rstmid:busy_before", {31'b0, bus.busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid:busy", {31'b0, bus.busy}, 32'd0);
    chk("rstmid:done", {31'b0, bus.done}, 32'd0);
    chk("rstmid:result", bus.result, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid:done_held", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("post_rst_2x3", 2'b00, 32'd2, 32'd3, 32'h0000_0006, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
